unidade_escrita_reg: RTL and testbench

//  Write-back unit driving the MIPS register-file write port (RegWrite, write reg number, write data).

---
 rtl/pacote_mips.sv | 15 +
 rtl/unidade_escrita_reg_if.sv | 29 ++
 rtl/fifo_escrita.sv | 53 +++++
 rtl/unidade_escrita_reg.sv | 104 ++++++++++
 tb/tb_unidade_escrita_reg.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pacote_mips.sv
// Shared MIPS write-back definitions: datapath widths and the {register, data}
// record passed between write-back, decode and the register file.
package pacote_mips;

  localparam int LARG_DADO = 32;
  localparam int LARG_REG  = 5;

  localparam logic [LARG_REG-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [LARG_REG-1:0]  num;
    logic [LARG_DADO-1:0] dado;
  } entrada_wb_t;

endpackage

// File: rtl/unidade_escrita_reg_if.sv
// Producer-side valid/ready channels (ALU path and load path) into the write-back unit.
interface unidade_escrita_reg_if #(
  parameter int LARG_DADO = pacote_mips::LARG_DADO,
  parameter int LARG_REG  = pacote_mips::LARG_REG
);

  logic                 valido_alu;
  logic [LARG_REG-1:0]  reg_alu;
  logic [LARG_DADO-1:0] dado_alu;
  logic                 pronto_alu;

  logic                 valido_mem;
  logic [LARG_REG-1:0]  reg_mem;
  logic [LARG_DADO-1:0] dado_mem;
  logic                 pronto_mem;

  modport master (
    output valido_alu, reg_alu, dado_alu,
    output valido_mem, reg_mem, dado_mem,
    input  pronto_alu, pronto_mem
  );

  modport slave (
    input  valido_alu, reg_alu, dado_alu,
    input  valido_mem, reg_mem, dado_mem,
    output pronto_alu, pronto_mem
  );

endinterface

// File: rtl/fifo_escrita.sv
// In-order write-back FIFO: up to two pushes (slot 0 first) and one pop per clock.
// Every entry is exposed oldest-first with a valid bit for hazard/forwarding compares.
module fifo_escrita
  import pacote_mips::*;
#(
  parameter  int PROF  = 4,
  localparam int PTR_W = $clog2(PROF),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push0,
  input  entrada_wb_t       entrada0,
  input  logic              push1,
  input  entrada_wb_t       entrada1,
  input  logic              pop,
  output logic [OCC_W-1:0]  ocupacao,
  output entrada_wb_t       entradas [PROF],
  output logic [PROF-1:0]   validos
);

  entrada_wb_t      mem [PROF];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // push1 is only ever raised together with push0, so it lands in the slot after push0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ocupacao <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      ocupacao <= ocupacao + OCC_W'(push0) + OCC_W'(push1) - OCC_W'(pop);
    end
  end

  // NOTE: storage has no reset; validity comes only from the pointers and ocupacao.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= entrada0;
    if (push1) mem[wr_ptr + PTR_W'(1)] <= entrada1;
  end

  // NOTE: every always_comb output is fully assigned each pass, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < PROF; i++) begin
      entradas[i] = mem[rd_ptr + PTR_W'(i)];
      validos[i]  = (i < int'(ocupacao));
    end
  end

endmodule

// File: rtl/unidade_escrita_reg.sv
// MIPS write-back unit: arbitrates ALU/load results into an in-order FIFO and retires one
// register write per clock; optional forwarding outputs are built when ENCAMINHAMENTO_EN is defined.
module unidade_escrita_reg
  import pacote_mips::*;
#(
  parameter  int PROF      = 4,
  parameter  int LARG_DADO = pacote_mips::LARG_DADO,
  parameter  int LARG_REG  = pacote_mips::LARG_REG,
  localparam int OCC_W     = $clog2(PROF) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unidade_escrita_reg_if.slave bus,
  output logic                 RegWrite,
  output logic [LARG_REG-1:0]  Numero_Reg_Escrita,
  output logic [LARG_DADO-1:0] Dado_escrita,
  input  logic [LARG_REG-1:0]  Numero_Reg1,
  input  logic [LARG_REG-1:0]  Numero_Reg2,
  output logic                 Pendente1,
  output logic                 Pendente2,
`ifdef ENCAMINHAMENTO_EN
  output logic [LARG_DADO-1:0] Valor_Fwd1,
  output logic [LARG_DADO-1:0] Valor_Fwd2,
`endif
  output logic [OCC_W-1:0]     ocupacao
);

  logic [OCC_W-1:0] livre;
  logic             push_mem;
  logic             push_alu;
  logic             pop;
  entrada_wb_t      e_mem;
  entrada_wb_t      e_alu;
  entrada_wb_t      entradas [PROF];
  logic [PROF-1:0]  validos;

  // Free space is judged from start-of-cycle occupancy; a same-cycle retire is not credited.
  assign livre          = OCC_W'(PROF) - ocupacao;
  assign bus.pronto_mem = (livre != '0);
  assign bus.pronto_alu = (livre >= OCC_W'(2)) || ((livre != '0) && !bus.valido_mem);

  // Writes to r0 complete the handshake but never occupy a slot.
  assign push_mem = bus.valido_mem && bus.pronto_mem && (bus.reg_mem != REG_ZERO);
  assign push_alu = bus.valido_alu && bus.pronto_alu && (bus.reg_alu != REG_ZERO);

  assign e_mem = '{num: bus.reg_mem, dado: bus.dado_mem};
  assign e_alu = '{num: bus.reg_alu, dado: bus.dado_alu};
  assign pop   = (ocupacao != '0);

  fifo_escrita #(.PROF(PROF)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0    (push_mem || push_alu),
    .entrada0 (push_mem ? e_mem : e_alu),
    .push1    (push_mem && push_alu),
    .entrada1 (e_alu),
    .pop      (pop),
    .ocupacao (ocupacao),
    .entradas (entradas),
    .validos  (validos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite           <= 1'b0;
      Numero_Reg_Escrita <= '0;
      Dado_escrita       <= '0;
    end else if (pop) begin
      RegWrite           <= 1'b1;
      Numero_Reg_Escrita <= entradas[0].num;
      Dado_escrita       <= entradas[0].dado;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  always_comb begin
    Pendente1 = RegWrite && (Numero_Reg_Escrita == Numero_Reg1);
    Pendente2 = RegWrite && (Numero_Reg_Escrita == Numero_Reg2);
    for (int i = 0; i < PROF; i++) begin
      if (validos[i] && (entradas[i].num == Numero_Reg1)) Pendente1 = 1'b1;
      if (validos[i] && (entradas[i].num == Numero_Reg2)) Pendente2 = 1'b1;
    end
    if (Numero_Reg1 == REG_ZERO) Pendente1 = 1'b0;
    if (Numero_Reg2 == REG_ZERO) Pendente2 = 1'b0;
  end

`ifdef ENCAMINHAMENTO_EN
  // Scan oldest to youngest (output register first) so the last match is the youngest write.
  always_comb begin
    Valor_Fwd1 = '0;
    Valor_Fwd2 = '0;
    if (RegWrite && (Numero_Reg_Escrita == Numero_Reg1)) Valor_Fwd1 = Dado_escrita;
    if (RegWrite && (Numero_Reg_Escrita == Numero_Reg2)) Valor_Fwd2 = Dado_escrita;
    for (int i = 0; i < PROF; i++) begin
      if (validos[i] && (entradas[i].num == Numero_Reg1)) Valor_Fwd1 = entradas[i].dado;
      if (validos[i] && (entradas[i].num == Numero_Reg2)) Valor_Fwd2 = entradas[i].dado;
    end
    if (Numero_Reg1 == REG_ZERO) Valor_Fwd1 = '0;
    if (Numero_Reg2 == REG_ZERO) Valor_Fwd2 = '0;
  end
`endif

endmodule

// File: tb/tb_unidade_escrita_reg.sv
// Directed bench for unidade_escrita_reg (PROF=4); forwarding checks run when ENCAMINHAMENTO_EN is defined.
module tb_unidade_escrita_reg;
  import pacote_mips::*;

  localparam int PROF  = 4;
  localparam int OCC_W = $clog2(PROF) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 RegWrite;
  logic [LARG_REG-1:0]  Numero_Reg_Escrita;
  logic [LARG_DADO-1:0] Dado_escrita;
  logic [LARG_REG-1:0]  Numero_Reg1;
  logic [LARG_REG-1:0]  Numero_Reg2;
  logic                 Pendente1;
  logic                 Pendente2;
  logic [OCC_W-1:0]     ocupacao;
`ifdef ENCAMINHAMENTO_EN
  logic [LARG_DADO-1:0] Valor_Fwd1;
  logic [LARG_DADO-1:0] Valor_Fwd2;
`endif

  always #5 clk = ~clk;

  unidade_escrita_reg_if #(.LARG_DADO(LARG_DADO), .LARG_REG(LARG_REG)) bus ();

  unidade_escrita_reg #(.PROF(PROF), .LARG_DADO(LARG_DADO), .LARG_REG(LARG_REG)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .RegWrite           (RegWrite),
    .Numero_Reg_Escrita (Numero_Reg_Escrita),
    .Dado_escrita       (Dado_escrita),
    .Numero_Reg1        (Numero_Reg1),
    .Numero_Reg2        (Numero_Reg2),
    .Pendente1          (Pendente1),
    .Pendente2          (Pendente2),
`ifdef ENCAMINHAMENTO_EN
    .Valor_Fwd1         (Valor_Fwd1),
    .Valor_Fwd2         (Valor_Fwd2),
`endif
    .ocupacao           (ocupacao)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic ocioso();
    bus.valido_alu = 1'b0;
    bus.reg_alu    = '0;
    bus.dado_alu   = '0;
    bus.valido_mem = 1'b0;
    bus.reg_mem    = '0;
    bus.dado_mem   = '0;
  endtask

  task automatic oferta_alu(input int r, input int d);
    bus.valido_alu = 1'b1;
    bus.reg_alu    = LARG_REG'(r);
    bus.dado_alu   = LARG_DADO'(d);
  endtask

  task automatic oferta_mem(input int r, input int d);
    bus.valido_mem = 1'b1;
    bus.reg_mem    = LARG_REG'(r);
    bus.dado_mem   = LARG_DADO'(d);
  endtask

  // Fill sequence: per step inputs, then expected ready (before edge) and outputs (after edge).
  // Load data is reg+100 so every retired value identifies its source.
  int fill_vm  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  int fill_rm  [9] = '{10, 12, 14, 16, 0, 0, 0, 0, 0};
  int fill_va  [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
  int fill_ra  [9] = '{11, 13, 15, 15, 15, 0, 0, 0, 0};
  int fill_pm  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int fill_pa  [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
  int fill_oc  [9] = '{2, 3, 3, 3, 3, 2, 1, 0, 0};
  int fill_rw  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int fill_num [9] = '{0, 10, 11, 12, 13, 14, 16, 15, 0};

  initial begin
    rst_n       = 1'b0;
    Numero_Reg1 = '0;
    Numero_Reg2 = '0;
    ocioso();

    // Reset state
    #12;
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_num",      64'(Numero_Reg_Escrita), 64'd0);
    check("rst_dado",     64'(Dado_escrita), 64'd0);
    check("rst_ocup",     64'(ocupacao), 64'd0);
    check("rst_pm",       64'(bus.pronto_mem), 64'd1);
    check("rst_pa",       64'(bus.pronto_alu), 64'd1);
    #1 rst_n = 1'b1;
    ciclo();

    // 1: single ALU write, visible two edges after acceptance for one cycle
    Numero_Reg1 = 5;
    oferta_alu(5, 'hA5);
    #1 check("t1_pa", 64'(bus.pronto_alu), 64'd1);
    ciclo();
    ocioso();
    check("t1_ocup_k",  64'(ocupacao), 64'd1);
    check("t1_rw_k",    64'(RegWrite), 64'd0);
    check("t1_pend_k",  64'(Pendente1), 64'd1);
    ciclo();
    check("t1_rw",      64'(RegWrite), 64'd1);
    check("t1_num",     64'(Numero_Reg_Escrita), 64'd5);
    check("t1_dado",    64'(Dado_escrita), 64'hA5);
    check("t1_pend",    64'(Pendente1), 64'd1);
    ciclo();
    check("t1_rw_off",  64'(RegWrite), 64'd0);
    check("t1_num_hld", 64'(Numero_Reg_Escrita), 64'd5);
    check("t1_pend_off", 64'(Pendente1), 64'd0);

    // 2: both sources in one cycle, load retires first
    Numero_Reg1 = 4;
    Numero_Reg2 = 3;
    oferta_mem(3, 7);
    oferta_alu(4, 9);
    #1;
    check("t2_pm", 64'(bus.pronto_mem), 64'd1);
    check("t2_pa", 64'(bus.pronto_alu), 64'd1);
    ciclo();
    ocioso();
    check("t2_ocup",   64'(ocupacao), 64'd2);
    check("t2_pend1a", 64'(Pendente1), 64'd1);
    check("t2_pend2a", 64'(Pendente2), 64'd1);
    ciclo();
    check("t2_rw1",    64'(RegWrite), 64'd1);
    check("t2_num1",   64'(Numero_Reg_Escrita), 64'd3);
    check("t2_dado1",  64'(Dado_escrita), 64'd7);
    check("t2_pend1b", 64'(Pendente1), 64'd1);
    ciclo();
    check("t2_rw2",    64'(RegWrite), 64'd1);
    check("t2_num2",   64'(Numero_Reg_Escrita), 64'd4);
    check("t2_dado2",  64'(Dado_escrita), 64'd9);
    check("t2_pend1c", 64'(Pendente1), 64'd1);
    check("t2_pend2c", 64'(Pendente2), 64'd0);
    ciclo();
    check("t2_rw_off", 64'(RegWrite), 64'd0);
    check("t2_pend1d", 64'(Pendente1), 64'd0);

    // 3: fill with both sources held valid
    for (int s = 0; s < 9; s++) begin
      ocioso();
      if (fill_vm[s] != 0) oferta_mem(fill_rm[s], fill_rm[s] + 100);
      if (fill_va[s] != 0) oferta_alu(fill_ra[s], fill_ra[s] + 100);
      #1;
      check($sformatf("t3_%0d_pm", s), 64'(bus.pronto_mem), 64'(fill_pm[s]));
      check($sformatf("t3_%0d_pa", s), 64'(bus.pronto_alu), 64'(fill_pa[s]));
      ciclo();
      check($sformatf("t3_%0d_ocup", s), 64'(ocupacao), 64'(fill_oc[s]));
      check($sformatf("t3_%0d_rw", s),   64'(RegWrite), 64'(fill_rw[s]));
      if (fill_rw[s] != 0) begin
        check($sformatf("t3_%0d_num", s),  64'(Numero_Reg_Escrita), 64'(fill_num[s]));
        check($sformatf("t3_%0d_dado", s), 64'(Dado_escrita), 64'(fill_num[s] + 100));
      end
    end
    ocioso();

    // 4: register 0 is accepted and dropped
    Numero_Reg1 = 0;
    oferta_alu(0, 'hFF);
    #1;
    check("t4_pa",    64'(bus.pronto_alu), 64'd1);
    check("t4_pend0", 64'(Pendente1), 64'd0);
    ciclo();
    ocioso();
    check("t4_ocup",  64'(ocupacao), 64'd0);
    check("t4_rw_a",  64'(RegWrite), 64'd0);
    check("t4_pend1", 64'(Pendente1), 64'd0);
    ciclo();
    check("t4_rw_b",  64'(RegWrite), 64'd0);

    // 5: asynchronous reset with three entries held
    Numero_Reg1 = 21;
    oferta_mem(20, 120);
    oferta_alu(21, 121);
    ciclo();
    oferta_mem(22, 122);
    oferta_alu(23, 123);
    ciclo();
    ocioso();
    check("t5_ocup_pre", 64'(ocupacao), 64'd3);
    check("t5_rw_pre",   64'(RegWrite), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rw",   64'(RegWrite), 64'd0);
    check("t5_ocup", 64'(ocupacao), 64'd0);
    check("t5_num",  64'(Numero_Reg_Escrita), 64'd0);
    check("t5_dado", 64'(Dado_escrita), 64'd0);
    check("t5_pend", 64'(Pendente1), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ciclo();
      check($sformatf("t5_post%0d_rw", c),   64'(RegWrite), 64'd0);
      check($sformatf("t5_post%0d_ocup", c), 64'(ocupacao), 64'd0);
    end

`ifdef ENCAMINHAMENTO_EN
    // 6: forwarding follows the youngest write to r7
    Numero_Reg1 = 7;
    Numero_Reg2 = 3;
    oferta_alu(7, 1);
    ciclo();
    check("t6_fwd_a",  64'(Valor_Fwd1), 64'd1);
    check("t6_fwd2_a", 64'(Valor_Fwd2), 64'd0);
    oferta_alu(7, 2);
    ciclo();
    ocioso();
    check("t6_fwd_b",  64'(Valor_Fwd1), 64'd2);
    check("t6_rw_b",   64'(RegWrite), 64'd1);
    check("t6_dado_b", 64'(Dado_escrita), 64'd1);
    ciclo();
    check("t6_fwd_c",  64'(Valor_Fwd1), 64'd2);
    check("t6_pend_c", 64'(Pendente1), 64'd1);
    ciclo();
    check("t6_fwd_d",  64'(Valor_Fwd1), 64'd0);
    check("t6_pend_d", 64'(Pendente1), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
